// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: the command op codes and the
// FSM state encoding. The sequencer top and the testbench both import this package.
package counter_sequencer_pkg;

  // Command op codes carried on cmd_op
  typedef enum logic [1:0] {
    OpStart  = 2'b00,
    OpPause  = 2'b01,
    OpResume = 2'b10,
    OpAbort  = 2'b11
  } cmd_op_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/count_core.sv
// count_core: WIDTH-bit up counter datapath driven by the sequencer FSM.
// Ports:
//   CLK   - clock; state updates on the rising edge
//   Reset - synchronous active-high reset, clears the count
//   clr   - synchronous clear; takes priority over en
//   en    - increment enable
//   q     - current count
module count_core #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for a WIDTH-bit up counter.
// Accepts START/PAUSE/RESUME/ABORT over valid/ready, runs the counter from 0 to a
// programmable limit in one-shot or auto-reload mode, and reports status.
// Ports:
//   CLK            - clock
//   Reset          - synchronous active-high reset; overrides all other inputs
//   cmd_valid      - command present
//   cmd_ready      - low only in the DONE state
//   cmd_op         - 00 START, 01 PAUSE, 10 RESUME, 11 ABORT
//   cmd_limit      - terminal count, sampled on START
//   cmd_autoreload - auto-reload mode, sampled on START
//   q              - current count
//   busy           - state is RUN or PAUSE
//   paused         - state is PAUSE
//   done           - one-cycle terminal-count pulse
//   reloads        - auto-reload wraps since last START, saturating
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned RLD_W = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_autoreload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [RLD_W-1:0] reloads
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             auto_q, auto_d;
  logic [RLD_W-1:0] reloads_q, reloads_d;
  logic             done_q, done_d;

  logic             clr, en;
  logic             accept;
  cmd_op_e          op;

  count_core #(
    .WIDTH (WIDTH)
  ) u_count_core (
    .CLK   (CLK),
    .Reset (Reset),
    .clr   (clr),
    .en    (en),
    .q     (q)
  );

  assign op     = cmd_op_e'(cmd_op);
  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    auto_d    = auto_q;
    reloads_d = reloads_q;
    done_d    = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && op == OpStart) begin
          limit_d   = cmd_limit;
          auto_d    = cmd_autoreload;
          reloads_d = '0;
          clr       = 1'b1;
          state_d   = StRun;
        end else if (accept && op == OpAbort) begin
          clr = 1'b1;
        end
      end

      StRun: begin
        // An accepted command (other than RESUME) pre-empts the terminal-count step
        if (accept && op == OpStart) begin
          limit_d   = cmd_limit;
          auto_d    = cmd_autoreload;
          reloads_d = '0;
          clr       = 1'b1;
        end else if (accept && op == OpPause) begin
          state_d = StPause;
        end else if (accept && op == OpAbort) begin
          clr     = 1'b1;
          state_d = StIdle;
        end else if (q != limit_q) begin
          en = 1'b1;
        end else if (auto_q) begin
          clr    = 1'b1;
          done_d = 1'b1;
          if (reloads_q != {RLD_W{1'b1}}) begin
            reloads_d = reloads_q + RLD_W'(1);
          end
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end

      StPause: begin
        if (accept && op == OpStart) begin
          limit_d   = cmd_limit;
          auto_d    = cmd_autoreload;
          reloads_d = '0;
          clr       = 1'b1;
          state_d   = StRun;
        end else if (accept && op == OpResume) begin
          state_d = StRun;
        end else if (accept && op == OpAbort) begin
          clr     = 1'b1;
          state_d = StIdle;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= StIdle;
      limit_q   <= '0;
      auto_q    <= 1'b0;
      reloads_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      auto_q    <= auto_d;
      reloads_q <= reloads_d;
      done_q    <= done_d;
    end
  end

  // Outputs are registers or pure decodes of the state register
  assign cmd_ready = (state_q != StDone);
  assign busy      = (state_q == StRun) || (state_q == StPause);
  assign paused    = (state_q == StPause);
  assign done      = done_q;
  assign reloads   = reloads_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios plus random
// commands, every cycle compared against a behavioural model.
module tb_counter_sequencer;

  localparam int unsigned WIDTH   = 7;
  localparam int unsigned RLD_W   = 4;
  localparam int          RLD_MAX = (1 << RLD_W) - 1;

  localparam logic [1:0] C_START  = 2'b00;
  localparam logic [1:0] C_PAUSE  = 2'b01;
  localparam logic [1:0] C_RESUME = 2'b10;
  localparam logic [1:0] C_ABORT  = 2'b11;

  // Model modes
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic             CLK = 1'b0;
  logic             Reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_limit = '0;
  logic             cmd_autoreload = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             paused;
  logic             done;
  logic [RLD_W-1:0] reloads;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode = M_IDLE;
  int m_q    = 0;
  int m_lim  = 0;
  int m_rl   = 0;
  bit m_auto = 1'b0;
  bit m_done = 1'b0;

  counter_sequencer #(
    .WIDTH (WIDTH),
    .RLD_W (RLD_W)
  ) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_limit      (cmd_limit),
    .cmd_autoreload (cmd_autoreload),
    .q              (q),
    .busy           (busy),
    .paused         (paused),
    .done           (done),
    .reloads        (reloads)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies one clock edge of the behavioural rules using the inputs at that edge
  task automatic model_edge();
    bit acc;
    if (Reset) begin
      m_mode = M_IDLE; m_q = 0; m_lim = 0; m_auto = 0; m_rl = 0; m_done = 0;
      return;
    end
    acc    = cmd_valid && (m_mode != M_DONE);
    m_done = 0;
    if (acc && cmd_op == C_START && m_mode != M_DONE) begin
      m_lim = int'(cmd_limit); m_auto = cmd_autoreload; m_q = 0; m_rl = 0; m_mode = M_RUN;
    end else if (acc && cmd_op == C_ABORT) begin
      m_q = 0; m_mode = M_IDLE;
    end else if (m_mode == M_PAUSE) begin
      if (acc && cmd_op == C_RESUME) m_mode = M_RUN;
    end else if (m_mode == M_DONE) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      if (acc && cmd_op == C_PAUSE) m_mode = M_PAUSE;
      else if (m_q < m_lim) m_q = m_q + 1;
      else if (m_auto) begin
        m_q = 0; m_done = 1; m_rl = (m_rl < RLD_MAX) ? m_rl + 1 : RLD_MAX;
      end else begin
        m_done = 1; m_mode = M_DONE;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_PAUSE));
    check("paused", 32'(paused), 32'(m_mode == M_PAUSE));
    check("done", 32'(done), 32'(m_done));
    check("reloads", 32'(reloads), 32'(m_rl));
    check("cmd_ready", 32'(cmd_ready), 32'(m_mode != M_DONE));
  endtask

  task automatic send(input logic [1:0] op, input int lim, input bit au);
    cmd_valid      = 1'b1;
    cmd_op         = op;
    cmd_limit      = WIDTH'(lim);
    cmd_autoreload = au;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // One-shot, limit 5
    send(C_START, 5, 1'b0);
    check("os_q_e0", 32'(q), 32'd0);
    repeat (5) tick();
    check("os_q_e5", 32'(q), 32'd5);
    check("os_done_e5", 32'(done), 32'd0);
    tick();
    check("os_done_e6", 32'(done), 32'd1);
    check("os_ready_e6", 32'(cmd_ready), 32'd0);
    tick();
    check("os_q_e7", 32'(q), 32'd5);
    check("os_busy_e7", 32'(busy), 32'd0);
    check("os_done_e7", 32'(done), 32'd0);

    // Auto-reload, limit 3
    send(C_START, 3, 1'b1);
    repeat (4) tick();
    check("ar_q_wrap1", 32'(q), 32'd0);
    check("ar_done_wrap1", 32'(done), 32'd1);
    check("ar_rl1", 32'(reloads), 32'd1);
    repeat (4) tick();
    check("ar_rl2", 32'(reloads), 32'd2);
    check("ar_busy", 32'(busy), 32'd1);
    send(C_ABORT, 0, 1'b0);
    check("ar_abort_q", 32'(q), 32'd0);

    // Pause / resume, limit 10
    send(C_START, 10, 1'b0);
    repeat (4) tick();
    send(C_PAUSE, 0, 1'b0);
    check("pr_q_pause", 32'(q), 32'd4);
    check("pr_paused", 32'(paused), 32'd1);
    repeat (5) tick();
    check("pr_q_held", 32'(q), 32'd4);
    send(C_RESUME, 0, 1'b0);
    check("pr_q_resume", 32'(q), 32'd4);
    tick();
    check("pr_q_next", 32'(q), 32'd5);
    repeat (5) tick();
    check("pr_q_end", 32'(q), 32'd10);
    tick();
    check("pr_done", 32'(done), 32'd1);
    tick();

    // Collisions at terminal count
    send(C_START, 6, 1'b0);
    repeat (6) tick();
    send(C_ABORT, 0, 1'b0);
    check("col_abort_q", 32'(q), 32'd0);
    check("col_abort_done", 32'(done), 32'd0);
    check("col_abort_busy", 32'(busy), 32'd0);
    send(C_START, 6, 1'b0);
    repeat (6) tick();
    send(C_START, 2, 1'b0);
    check("col_start_q", 32'(q), 32'd0);
    check("col_start_done", 32'(done), 32'd0);
    repeat (4) tick();

    // Reset mid-run with a START presented
    send(C_START, 20, 1'b0);
    repeat (7) tick();
    Reset          = 1'b1;
    cmd_valid      = 1'b1;
    cmd_op         = C_START;
    cmd_limit      = WIDTH'(9);
    tick();
    Reset     = 1'b0;
    cmd_valid = 1'b0;
    check("rmr_q", 32'(q), 32'd0);
    check("rmr_busy", 32'(busy), 32'd0);
    check("rmr_rl", 32'(reloads), 32'd0);
    tick();
    check("rmr_idle", 32'(busy), 32'd0);

    // Limit 0 one-shot and saturating auto-reload
    send(C_START, 0, 1'b0);
    check("l0_busy", 32'(busy), 32'd1);
    tick();
    check("l0_done", 32'(done), 32'd1);
    tick();
    send(C_START, 0, 1'b1);
    repeat (20) tick();
    check("l0_sat", 32'(reloads), 32'(RLD_MAX));
    check("l0_auto_done", 32'(done), 32'd1);
    send(C_ABORT, 0, 1'b0);

    // Full range
    send(C_START, 127, 1'b0);
    repeat (127) tick();
    check("l127_q", 32'(q), 32'd127);
    tick();
    check("l127_done", 32'(done), 32'd1);
    tick();

    // Random commands
    for (int i = 0; i < 3000; i++) begin
      Reset          = ($urandom_range(0, 199) == 0);
      cmd_valid      = ($urandom_range(0, 3) == 0);
      cmd_op         = 2'($urandom_range(0, 3));
      cmd_limit      = ($urandom_range(0, 9) == 0) ? WIDTH'(127) : WIDTH'($urandom_range(0, 12));
      cmd_autoreload = 1'($urandom_range(0, 1));
      tick();
    end
    Reset     = 1'b0;
    cmd_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
